uart_alu_sequencer: RTL and testbench
=====================================

Name: uart_alu_sequencer

Overview:
- Command sequencer between the UART core (rx/tx) and the combinational ALU.
- Collects three bytes from the UART receiver, in order operand A, operand B, opcode, and drives them to the ALU as registered outputs.
- Captures the ALU result and launches one UART transmission of it, then waits for tx completion before accepting the next command.
- Includes an inter-byte timeout that discards partially received commands.

Parameters:
- NB_DATA, 8: UART byte width; also the ALU operand and result width.
- NB_OP, 6: ALU opcode width, taken from the opcode byte bits [NB_OP-1:0]. Must satisfy NB_OP <= NB_DATA.
- TIMEOUT_CYCLES, 100000000: clock cycles allowed between consecutive bytes of one command.
- NB_TIMEOUT, $clog2(TIMEOUT_CYCLES): timeout counter width.

Ports:
- i_clock  in  1  system clock. This is the block's only clock.
- i_reset  in  1  reset. It is synchronous and active-high.
- i_rx_data_valid  in  1  one-cycle pulse from the UART rx: a byte is available.
- i_rx_data  in  NB_DATA  received byte. Valid only when i_rx_data_valid is high.
- i_tx_done  in  1  one-cycle pulse from the UART tx at the end of its stop bit.
- i_alu_result  in  NB_DATA  combinational ALU result for the current o_alu_* values.
- o_alu_data_a  out  NB_DATA  registered operand A.
- o_alu_data_b  out  NB_DATA  registered operand B.
- o_alu_opcode  out  NB_OP  registered opcode.
- o_tx_data  out  NB_DATA  byte to transmit. Registered, held stable until the next capture.
- o_tx_start  out  1  one-cycle pulse that starts the UART tx.
- o_timeout  out  1  one-cycle pulse: a partial command was discarded.
- o_busy  out  1  high in EXEC, TX_START and TX_WAIT.

Behaviour:
- Reset (any cycle, any state):
  - State goes to RX_A; timeout counter goes to 0.
  - All outputs are 0: o_alu_data_a, o_alu_data_b, o_alu_opcode, o_tx_data, o_tx_start, o_timeout, o_busy.
  - A reset that hits mid-command or mid-transmission abandons that command. No o_tx_start is issued afterwards.
- States and transitions:
  - RX_A: on valid, o_alu_data_a <= i_rx_data; go to RX_B. No timeout in this state (idle wait).
  - RX_B: on valid, o_alu_data_b <= i_rx_data; go to RX_OP.
  - RX_OP: on valid, o_alu_opcode <= i_rx_data[NB_OP-1:0]; go to EXEC. Upper opcode bits are ignored.
  - EXEC (exactly 1 cycle): o_tx_data <= i_alu_result; go to TX_START. The ALU sees stable registered inputs throughout this cycle.
  - TX_START (exactly 1 cycle): o_tx_start = 1; go to TX_WAIT.
  - TX_WAIT: on i_tx_done, go to RX_A. Wait is unbounded, with no timeout.
- Latency:
  - Opcode valid at cycle t: o_alu_opcode updates and EXEC is active at t+1.
  - o_tx_data updates at t+2, with o_tx_start high during t+2 only.
- Timeout:
  - The counter runs only in RX_B and RX_OP. It clears on every accepted byte and on entry to RX_A.
  - If it reaches TIMEOUT_CYCLES-1 with no valid that cycle: go to RX_A, pulse o_timeout for 1 cycle, clear the counter.
  - Operand registers keep their stale values.
  - Valid in the same cycle as expiry: the byte is accepted, no timeout.
- Ignored events:
  - i_rx_data_valid in EXEC, TX_START or TX_WAIT is dropped. It is not buffered and is not counted as a command byte.
  - i_tx_done outside TX_WAIT is ignored.
  - i_tx_done in TX_START is ignored; the block still enters TX_WAIT.
- Outputs are registered only; no combinational path from inputs to outputs.
- o_busy is a registered decode of the state.

Test Plan:
- Reset, then bytes 0x05, 0x03, 0x20 (bench ALU: 0x20 = ADD):
  - o_alu_data_a = 0x05, o_alu_data_b = 0x03, o_alu_opcode = 0x20.
  - o_tx_data = 0x08 and a single o_tx_start pulse 2 cycles after the opcode valid.
  - o_busy stays high until the i_tx_done pulse.
- Back-to-back commands:
  - First command: 0xF0, 0x0F, 0x24 (AND) yields o_tx_data = 0x00.
  - After i_tx_done, second command 0xFF, 0x01, 0x20 yields o_tx_data = 0x00 (wrap).
  - Exactly 2 o_tx_start pulses in total.
- With TIMEOUT_CYCLES=16:
  - Send 0x11, then nothing for 16 cycles: o_timeout pulses once; state RX_A.
  - Then send 0x02, 0x03, 0x20: o_tx_data = 0x05, so the stale 0x11 is not used.
- With TIMEOUT_CYCLES=16, byte valid exactly on cycle 15 after the previous byte: no o_timeout; the byte is accepted.
- Send 0xAA while in TX_WAIT: no register change; the next full command 0x01, 0x01, 0x20 gives o_tx_data = 0x02.
- Assert i_reset for 1 cycle in TX_WAIT:
  - All outputs go to 0 and no o_tx_start follows.
  - A subsequent i_tx_done is ignored.
  - A new command completes normally.

Source files
------------

// File: rtl/uart_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : uart_alu_sequencer
// Brief   : Collects A/B/opcode bytes from UART rx, drives the ALU, and sends
//           the result back through UART tx, with an inter-byte timeout.
// Rev     : 1.0
// ============================================================================
module uart_alu_sequencer #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int NB_TIMEOUT     = $clog2(TIMEOUT_CYCLES)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_data_valid,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_data_a,
    output logic [NB_DATA-1:0] o_alu_data_b,
    output logic [NB_OP-1:0]   o_alu_opcode,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_timeout,
    output logic               o_busy
);

    typedef enum logic [2:0] {
        RX_A     = 3'd0,
        RX_B     = 3'd1,
        RX_OP    = 3'd2,
        EXEC     = 3'd3,
        TX_START = 3'd4,
        TX_WAIT  = 3'd5
    } state_t;

    localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);
    localparam logic [NB_TIMEOUT-1:0] CNT_ONE      = NB_TIMEOUT'(1);

    state_t                  state;
    state_t                  state_next;
    logic [NB_TIMEOUT-1:0]   timeout_cnt;
    logic [NB_TIMEOUT-1:0]   timeout_cnt_next;
    logic [NB_DATA-1:0]      data_a_next;
    logic [NB_DATA-1:0]      data_b_next;
    logic [NB_OP-1:0]        opcode_next;
    logic [NB_DATA-1:0]      tx_data_next;
    logic                    tx_start_next;
    logic                    timeout_next;
    logic                    busy_next;
    logic                    timeout_hit;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= RX_A;
            timeout_cnt  <= '0;
            o_alu_data_a <= '0;
            o_alu_data_b <= '0;
            o_alu_opcode <= '0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_timeout    <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state        <= state_next;
            timeout_cnt  <= timeout_cnt_next;
            o_alu_data_a <= data_a_next;
            o_alu_data_b <= data_b_next;
            o_alu_opcode <= opcode_next;
            o_tx_data    <= tx_data_next;
            o_tx_start   <= tx_start_next;
            o_timeout    <= timeout_next;
            o_busy       <= busy_next;
        end
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST) && !i_rx_data_valid;

    always_comb begin
        state_next       = state;
        timeout_cnt_next = timeout_cnt;
        data_a_next      = o_alu_data_a;
        data_b_next      = o_alu_data_b;
        opcode_next      = o_alu_opcode;
        tx_data_next     = o_tx_data;
        timeout_next     = 1'b0;

        case (state)
            RX_A: begin
                timeout_cnt_next = '0;
                if (i_rx_data_valid) begin
                    data_a_next = i_rx_data;
                    state_next  = RX_B;
                end
            end
            RX_B: begin
                if (i_rx_data_valid) begin
                    data_b_next      = i_rx_data;
                    timeout_cnt_next = '0;
                    state_next       = RX_OP;
                end else if (timeout_hit) begin
                    timeout_cnt_next = '0;
                    timeout_next     = 1'b1;
                    state_next       = RX_A;
                end else begin
                    timeout_cnt_next = timeout_cnt + CNT_ONE;
                end
            end
            RX_OP: begin
                if (i_rx_data_valid) begin
                    opcode_next      = i_rx_data[NB_OP-1:0];
                    timeout_cnt_next = '0;
                    state_next       = EXEC;
                end else if (timeout_hit) begin
                    timeout_cnt_next = '0;
                    timeout_next     = 1'b1;
                    state_next       = RX_A;
                end else begin
                    timeout_cnt_next = timeout_cnt + CNT_ONE;
                end
            end
            EXEC: begin
                tx_data_next = i_alu_result;
                state_next   = TX_START;
            end
            TX_START: begin
                state_next = TX_WAIT;
            end
            TX_WAIT: begin
                if (i_tx_done) begin
                    state_next = RX_A;
                end
            end
            default: begin
                state_next       = RX_A;
                timeout_cnt_next = '0;
            end
        endcase

        // Flag outputs are registered decodes of the state being entered.
        tx_start_next = (state_next == TX_START);
        busy_next     = (state_next == EXEC) || (state_next == TX_START) ||
                        (state_next == TX_WAIT);
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_alu_sequencer
// Brief   : Randomized self-checking bench with a behavioural ALU/command model.
// Rev     : 1.0
// ============================================================================
module tb_uart_alu_sequencer;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TO_CYC  = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               rx_valid;
    logic [NB_DATA-1:0] rx_data;
    logic               tx_done;
    logic [NB_DATA-1:0] alu_result;
    logic [NB_DATA-1:0] alu_a;
    logic [NB_DATA-1:0] alu_b;
    logic [NB_OP-1:0]   alu_op;
    logic [NB_DATA-1:0] tx_data;
    logic               tx_start;
    logic               timeout;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;
    int start_count = 0;
    int to_count    = 0;

    uart_alu_sequencer #(
        .NB_DATA        (NB_DATA),
        .NB_OP          (NB_OP),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_rx_data_valid (rx_valid),
        .i_rx_data       (rx_data),
        .i_tx_done       (tx_done),
        .i_alu_result    (alu_result),
        .o_alu_data_a    (alu_a),
        .o_alu_data_b    (alu_b),
        .o_alu_opcode    (alu_op),
        .o_tx_data       (tx_data),
        .o_tx_start      (tx_start),
        .o_timeout       (timeout),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            6'h03:   return $signed(a) >>> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    // Pulses are counted on the edge that ends their cycle.
    always @(posedge clk) begin
        if (tx_start) start_count++;
        if (timeout)  to_count++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_a"},     32'(alu_a),    32'h0);
        check_val({tag, "_b"},     32'(alu_b),    32'h0);
        check_val({tag, "_op"},    32'(alu_op),   32'h0);
        check_val({tag, "_txd"},   32'(tx_data),  32'h0);
        check_val({tag, "_start"}, 32'(tx_start), 32'h0);
        check_val({tag, "_to"},    32'(timeout),  32'h0);
        check_val({tag, "_busy"},  32'(busy),     32'h0);
    endtask

    // Full command: bytes with exact idle gaps, optional junk byte in TX_WAIT,
    // optional tx_done during TX_START (must be ignored).
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int gap_ab, input int gap_bop, input bit junk, input bit early);
        logic [7:0] exp;
        int s0;
        exp = alu_model(a, b, op[5:0]);
        s0  = start_count;
        send_byte(a);
        idle(gap_ab);
        send_byte(b);
        idle(gap_bop);
        send_byte(op);
        check_val("exec_a",     32'(alu_a),    32'(a));
        check_val("exec_b",     32'(alu_b),    32'(b));
        check_val("exec_op",    32'(alu_op),   32'(op[5:0]));
        check_val("exec_busy",  32'(busy),     32'h1);
        check_val("exec_start", 32'(tx_start), 32'h0);
        @(negedge clk);
        check_val("txs_start",  32'(tx_start), 32'h1);
        check_val("txs_data",   32'(tx_data),  32'(exp));
        if (early) tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_val("txw_start",  32'(tx_start), 32'h0);
        check_val("txw_busy",   32'(busy),     32'h1);
        if (junk) begin
            send_byte(8'hAA);
            check_val("junk_a",  32'(alu_a),   32'(a));
            check_val("junk_b",  32'(alu_b),   32'(b));
            check_val("junk_op", 32'(alu_op),  32'(op[5:0]));
            check_val("junk_txd", 32'(tx_data), 32'(exp));
        end
        idle($urandom_range(0, 5));
        check_val("wait_busy", 32'(busy), 32'h1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_val("done_busy",   32'(busy),          32'h0);
        check_val("done_starts", 32'(start_count - s0), 32'h1);
        check_val("done_txd",    32'(tx_data),       32'(exp));
    endtask

    initial begin
        int s0;
        int t0;
        logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        tx_done  = 1'b0;
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;
        idle(2);

        run_cmd(8'h05, 8'h03, 8'h20, 0, 0, 1'b0, 1'b0);

        s0 = start_count;
        run_cmd(8'hF0, 8'h0F, 8'h24, 0, 0, 1'b0, 1'b0);
        run_cmd(8'hFF, 8'h01, 8'h20, 0, 0, 1'b0, 1'b0);
        check_val("b2b_starts", 32'(start_count - s0), 32'h2);

        // Partial command abandoned by the inter-byte timeout.
        t0 = to_count;
        send_byte(8'h11);
        idle(TO_CYC - 1);
        check_val("to_early", 32'(timeout), 32'h0);
        @(negedge clk);
        check_val("to_pulse", 32'(timeout), 32'h1);
        @(negedge clk);
        check_val("to_one_cycle", 32'(timeout), 32'h0);
        check_val("to_count",  32'(to_count - t0), 32'h1);
        check_val("to_stale_a", 32'(alu_a), 32'h11);
        check_val("to_busy",    32'(busy),  32'h0);
        run_cmd(8'h02, 8'h03, 8'h20, 0, 0, 1'b0, 1'b0);

        // Byte landing exactly on the expiry cycle is accepted.
        t0 = to_count;
        run_cmd(8'h07, 8'h09, 8'h26, TO_CYC - 1, TO_CYC - 1, 1'b0, 1'b0);
        check_val("edge_no_to", 32'(to_count - t0), 32'h0);

        run_cmd(8'h12, 8'h34, 8'h25, 1, 2, 1'b1, 1'b0);
        run_cmd(8'h01, 8'h01, 8'h20, 0, 0, 1'b0, 1'b1);

        // Reset while in TX_WAIT.
        send_byte(8'h40);
        send_byte(8'h41);
        send_byte(8'h22);
        idle(2);
        s0  = start_count;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst_txw");
        idle(4);
        check_val("rst_no_start", 32'(start_count - s0), 32'h0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        idle(2);
        check_val("rst_done_busy", 32'(busy), 32'h0);
        check_val("rst_no_start2", 32'(start_count - s0), 32'h0);
        run_cmd(8'h09, 8'h04, 8'h22, 0, 0, 1'b0, 1'b0);

        // Randomized commands with occasional abandoned partials.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                t0 = to_count;
                send_byte(8'($urandom));
                if ($urandom_range(0, 1) == 1) begin
                    idle($urandom_range(0, TO_CYC - 1));
                    send_byte(8'($urandom));
                end
                idle(TO_CYC + 1);
                check_val("rnd_to_count", 32'(to_count - t0), 32'h1);
                check_val("rnd_to_busy",  32'(busy), 32'h0);
            end
            run_cmd(8'($urandom), 8'($urandom),
                    {2'($urandom), ops[$urandom_range(0, 7)]},
                    $urandom_range(0, TO_CYC - 1), $urandom_range(0, TO_CYC - 1),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
